// File: rtl/sim_exit_responder.sv
// Memory-mapped console/exit/cycle-counter device that ends a simulation run.
// A store to EXIT drains the console FIFO and then raises a sticky done; a watchdog forces a timeout.
module sim_exit_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'hFFFF_FF00,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic        timeout,
  output logic [31:0] exit_code,
  output logic [63:0] cycles
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
  localparam logic [63:0] WdLast = 64'(TIMEOUT_CYCLES) - 64'd1;

  localparam logic [1:0] RegConsole = 2'd0;
  localparam logic [1:0] RegExit    = 2'd1;
  localparam logic [1:0] RegCycLo   = 2'd2;
  localparam logic [1:0] RegCycHi   = 2'd3;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [63:0] cycles_q;
  logic [31:0] exit_code_q;
  logic        timeout_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  logic        in_window, fifo_full, fifo_empty;
  logic [1:0]  reg_sel;
  logic        accept, push, pop, exit_wr, load, wd_fire;
  logic [31:0] load_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[1:0];

  assign in_window  = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel    = req_addr[3:2];
  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);

  // A pop in the same cycle does not make room for a push: the store is refused while full.
  assign req_ready = in_window && (state_q == StRun) &&
                     !(req_we && (reg_sel == RegConsole) && fifo_full);

  assign accept  = req_valid && req_ready;
  assign push    = accept && req_we && (reg_sel == RegConsole);
  assign exit_wr = accept && req_we && (reg_sel == RegExit);
  assign load    = accept && !req_we;
  assign pop     = !fifo_empty && tx_ready;
  assign wd_fire = (state_q == StRun) && (cycles_q == WdLast);

  always_comb begin
    load_data = 32'd0;
    unique case (reg_sel)
      RegCycLo: load_data = cycles_q[31:0];
      RegCycHi: load_data = cycles_q[63:32];
      default:  load_data = 32'd0;
    endcase
  end

  // Watchdog takes priority over an EXIT store landing on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (wd_fire) begin
          state_d = StDone;
        end else if (exit_wr) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      cycles_q    <= 64'd0;
      exit_code_q <= 32'd0;
      timeout_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= load;
      if (load) begin
        rsp_rdata_q <= load_data;
      end
      // The firing edge leaves the count at TIMEOUT_CYCLES-1.
      if (state_q != StDone && !wd_fire) begin
        cycles_q <= cycles_q + 64'd1;
      end
      if (wd_fire) begin
        timeout_q   <= 1'b1;
        exit_code_q <= 32'hFFFF_FFFF;
      end else if (exit_wr) begin
        exit_code_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (wd_fire) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= req_wdata[7:0];
    end
  end

  assign tx_valid  = !fifo_empty;
  assign tx_data   = fifo_mem[rd_ptr_q];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign done      = (state_q == StDone);
  assign timeout   = timeout_q;
  assign exit_code = exit_code_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_sim_exit_responder.sv
// Randomized self-checking bench for sim_exit_responder; expected console stream is a queue model,
// expected cycle values come from an independent edge counter.
module tb_sim_exit_responder;

  localparam logic [31:0] Base = 32'hFFFF_FF00;

  logic        clk, reset;
  logic        req_valid, req_we, tx_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, tx_valid, done, timeout;
  logic [31:0] rsp_rdata, exit_code;
  logic [7:0]  tx_data;
  logic [63:0] cycles;

  logic        to_req_ready, to_rsp_valid, to_tx_valid, to_done, to_timeout;
  logic [31:0] to_rsp_rdata, to_exit_code;
  logic [7:0]  to_tx_data;
  logic [63:0] to_cycles;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [63:0] edges;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  bit          rand_ready_en = 1'b0;

  sim_exit_responder #(
    .BASE_ADDR(Base), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(2000)
  ) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .done(done),
    .timeout(timeout), .exit_code(exit_code), .cycles(cycles)
  );

  sim_exit_responder #(
    .BASE_ADDR(Base), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(20)
  ) u_dut_to (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(to_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(to_rsp_valid),
    .rsp_rdata(to_rsp_rdata), .tx_valid(to_tx_valid), .tx_data(to_tx_data),
    .tx_ready(tx_ready), .done(to_done), .timeout(to_timeout), .exit_code(to_exit_code),
    .cycles(to_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 64'd0;
    else       edges <= edges + 64'd1;
  end

  always @(posedge clk) begin
    if (!reset && tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  always @(negedge clk) begin
    if (rand_ready_en) tx_ready = 1'($urandom_range(0, 1));
  end

  task automatic apply_reset();
    rand_ready_en = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    tx_ready  = 1'b0;
    reset     = 1'b1;
    #3;
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, output bit ok, output logic [63:0] cyc);
    ok  = 1'b0;
    cyc = 64'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = $urandom;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready) begin
        cyc = edges;
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; tx_ready = 1'b0;
    req_addr = Base; req_wdata = 32'd0;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    n_cmp++; if (exit_code !== 32'd0) begin n_bad++; $display("FAIL reset_exit got=%h want=0", exit_code); end
    n_cmp++; if (cycles !== 64'd0) begin n_bad++; $display("FAIL reset_cycles got=%0d want=0", cycles); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_rsp got=%b/%h want=0/0", rsp_valid, rsp_rdata);
    end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
    apply_reset();
  endtask

  task automatic test_hi();
    bit ok0, ok1, ok2, okd;
    apply_reset();
    tx_ready = 1'b1;
    exp_q = '{8'h48, 8'h69};
    do_store(Base, 32'h48, ok0);
    do_store(Base, 32'h69, ok1);
    do_store(Base + 32'd4, 32'd0, ok2);
    wait_done(50, okd);
    n_cmp++; if (!(ok0 && ok1 && ok2 && okd)) begin
      n_bad++; $display("FAIL hi_handshake got=%b%b%b%b want=1111", ok0, ok1, ok2, okd);
    end
    n_cmp++; if (got_q != exp_q) begin
      n_bad++; $display("FAIL hi_stream got=%p want=%p", got_q, exp_q);
    end
    n_cmp++; if (exit_code !== 32'd0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL hi_status got=%h/%b want=0/0", exit_code, timeout);
    end
  endtask

  task automatic test_console_random();
    for (int it = 0; it < 3; it++) begin
      int unsigned n;
      logic [31:0] code;
      bit ok, all_ok;
      apply_reset();
      n = $urandom_range(1, 20);
      code = $urandom;
      all_ok = 1'b1;
      rand_ready_en = 1'b1;
      for (int k = 0; k < n; k++) begin
        logic [31:0] w;
        w = $urandom;
        exp_q.push_back(w[7:0]);
        do_store(Base | 32'($urandom_range(0, 3)), w, ok);
        all_ok &= ok;
      end
      do_store(Base + 32'd4, code, ok);
      all_ok &= ok;
      wait_done(600, ok);
      all_ok &= ok;
      rand_ready_en = 1'b0;
      n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL rand_handshake it=%0d got=0 want=1", it); end
      n_cmp++; if (got_q != exp_q) begin
        n_bad++; $display("FAIL rand_stream it=%0d got=%p want=%p", it, got_q, exp_q);
      end
      n_cmp++; if (exit_code !== code || timeout !== 1'b0) begin
        n_bad++; $display("FAIL rand_exit it=%0d got=%h/%b want=%h/0", it, exit_code, timeout, code);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, all_ok;
    logic [31:0] w;
    apply_reset();
    all_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      exp_q.push_back(w[7:0]);
      do_store(Base, w, ok);
      all_ok &= ok;
    end
    n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL bp_fill got=0 want=1"); end
    w = $urandom;
    exp_q.push_back(w[7:0]);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = Base; req_wdata = w;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready got=%b want=0", req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      n_bad++; $display("FAIL bp_hold got=%b/%b/%h want=0/1/%h", req_ready, tx_valid, tx_data, exp_q[0]);
    end
    tx_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pop_cycle got=%b want=0", req_ready); end
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_after_pop got=%b want=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    do_store(Base + 32'd4, 32'd0, ok);
    all_ok = ok;
    wait_done(60, ok);
    all_ok &= ok;
    n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL bp_done got=0 want=1"); end
    n_cmp++; if (got_q != exp_q) begin
      n_bad++; $display("FAIL bp_stream got=%p want=%p", got_q, exp_q);
    end
  endtask

  task automatic test_drain();
    bit ok, all_ok;
    logic [31:0] code, w;
    logic [63:0] exp_cyc;
    apply_reset();
    all_ok = 1'b1;
    code = 32'd5 + ($urandom & 32'hFF);
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      exp_q.push_back(w[7:0]);
      do_store(Base, w, ok);
      all_ok &= ok;
    end
    do_store(Base + 32'd4, code, ok);
    all_ok &= ok;
    n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL drain_fill got=0 want=1"); end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = Base; req_wdata = 32'h41;
    #1;
    n_cmp++; if (done !== 1'b0 || tx_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_bad++; $display("FAIL drain_hold got=%b/%b/%b want=0/1/0", done, tx_valid, req_ready);
    end
    req_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0 || tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL drain_last_pop got=%b/%b want=0/0", done, tx_valid);
    end
    @(posedge clk); #1;
    exp_cyc = edges;
    n_cmp++; if (done !== 1'b1 || exit_code !== code || timeout !== 1'b0) begin
      n_bad++; $display("FAIL drain_done got=%b/%h/%b want=1/%h/0", done, exit_code, timeout, code);
    end
    n_cmp++; if (got_q != exp_q) begin
      n_bad++; $display("FAIL drain_stream got=%p want=%p", got_q, exp_q);
    end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (cycles !== exp_cyc || done !== 1'b1) begin
      n_bad++; $display("FAIL drain_frozen got=%0d/%b want=%0d/1", cycles, done, exp_cyc);
    end
    req_valid = 1'b1; req_we = 1'b1; req_addr = Base + 32'd4;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL drain_ready got=%b want=0", req_ready); end
    req_valid = 1'b0;
  endtask

  task automatic test_load();
    bit ok;
    logic [63:0] cyc;
    logic [31:0] bad_addr[4];
    apply_reset();
    while (edges < 64'd6) @(negedge clk);
    do_load(Base + 32'd8, ok, cyc);
    n_cmp++; if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== cyc[31:0]) begin
      n_bad++; $display("FAIL load_lo7 got=%b/%0d want=1/%0d", rsp_valid, rsp_rdata, cyc);
    end
    @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL load_pulse got=%b want=0", rsp_valid); end
    for (int it = 0; it < 4; it++) begin
      logic [1:0] sel;
      logic [31:0] want;
      repeat ($urandom_range(0, 12)) @(negedge clk);
      sel = 2'($urandom_range(0, 3));
      do_load(Base | {28'd0, sel, 2'b00}, ok, cyc);
      want = (sel == 2'd2) ? cyc[31:0] : (sel == 2'd3) ? cyc[63:32] : 32'd0;
      n_cmp++; if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== want) begin
        n_bad++; $display("FAIL load_rand sel=%0d got=%b/%h want=1/%h", sel, rsp_valid, rsp_rdata, want);
      end
    end
    bad_addr = '{Base + 32'd16, Base - 32'd4, 32'h0000_0008, $urandom & 32'h7FFF_FFFF};
    foreach (bad_addr[i]) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'(i % 2); req_addr = bad_addr[i]; req_wdata = 32'h55;
      #1;
      n_cmp++; if (req_ready !== 1'b0) begin
        n_bad++; $display("FAIL load_window addr=%h got=%b want=0", bad_addr[i], req_ready);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (tx_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL load_window_effect got=%b/%b want=0/0", tx_valid, rsp_valid);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    apply_reset();
    do_store(Base, 32'h7A, ok);
    while (edges < 64'd19) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = Base + 32'd4; req_wdata = 32'h1234;
    #1;
    n_cmp++; if (to_done !== 1'b0 || to_tx_valid !== 1'b1 || to_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL to_before got=%b/%b/%b want=0/1/1", to_done, to_tx_valid, to_req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (to_done !== 1'b1 || to_timeout !== 1'b1 || to_exit_code !== 32'hFFFF_FFFF) begin
      n_bad++; $display("FAIL to_fire got=%b/%b/%h want=1/1/ffffffff", to_done, to_timeout, to_exit_code);
    end
    n_cmp++; if (to_cycles !== 64'd19 || to_tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL to_state got=%0d/%b want=19/0", to_cycles, to_tx_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (to_cycles !== 64'd19 || to_done !== 1'b1) begin
      n_bad++; $display("FAIL to_frozen got=%0d/%b want=19/1", to_cycles, to_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok, all_ok;
    logic [63:0] cyc;
    logic [31:0] w;
    apply_reset();
    all_ok = 1'b1;
    do_store(Base, 32'h31, ok); all_ok &= ok;
    do_store(Base, 32'h32, ok); all_ok &= ok;
    do_load(Base + 32'd8, ok, cyc); all_ok &= ok;
    do_store(Base + 32'd4, 32'd9, ok); all_ok &= ok;
    @(negedge clk); #1;
    n_cmp++; if (!all_ok || done !== 1'b0 || tx_valid !== 1'b1 || exit_code !== 32'd9) begin
      n_bad++; $display("FAIL rmd_setup got=%b/%b/%h want=0/1/9", done, tx_valid, exit_code);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || done !== 1'b0 || exit_code !== 32'd0 || cycles !== 64'd0 ||
                 rsp_rdata !== 32'd0 || rsp_valid !== 1'b0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL rmd_async got=%b/%b/%h/%0d/%h want=0/0/0/0/0",
                        tx_valid, done, exit_code, cycles, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx_valid !== 1'b0 || got_q.size() != 0 || cycles !== edges || done !== 1'b0) begin
      n_bad++; $display("FAIL rmd_after got=%b/%0d/%0d/%b want=0/0/%0d/0",
                        tx_valid, got_q.size(), cycles, done, edges);
    end
    w = $urandom;
    do_store(Base, w, ok);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (!ok || got_q.size() != 1 || got_q[0] !== w[7:0]) begin
      n_bad++; $display("FAIL rmd_resume got=%0d want=1 byte %h", got_q.size(), w[7:0]);
    end
  endtask

  initial begin
    test_reset();
    test_hi();
    test_console_random();
    test_backpressure();
    test_drain();
    test_load();
    test_timeout();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
